fpu_op_queue: RTL and testbench

- Parametrised command/response front-end for the FPU datapath. Replaces direct one-shot operand-register dispatch.
- Buffers up to CMD_DEPTH tagged operations and issues them one at a time to the FPU units. Single-cycle units and multi-cycle div/sqrt are handled identically.
- Completed results and exceptions go to a RSP_DEPTH response FIFO. Sticky RISC-V fflags and a response interrupt are kept.
- Sits between the wishbone/LA register file and the FPU unit bank.

---
 rtl/fpu_op_queue.sv | 230 +++++++++++++++++++++++
 tb/tb_fpu_op_queue.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_op_queue.sv
// Tagged command/response queue in front of the FPU unit bank: buffers commands, issues one at a time.
// Optional FPQ_TIMEOUT_EN: abort an operation whose unit never returns fu_done within TIMEOUT cycles.
module fpu_op_queue #(
   parameter int unsigned CMD_DEPTH = 4,
   parameter int unsigned RSP_DEPTH = 4,
   parameter int unsigned TAG_W     = 4,
   parameter int unsigned NUM_OPS   = 11,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [1:0]       cmd_sub,
   input  logic [2:0]       cmd_rm,
   input  logic [31:0]      cmd_a,
   input  logic [31:0]      cmd_b,
   input  logic [31:0]      cmd_c,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic             iss_valid,
   output logic [3:0]       iss_op,
   output logic [1:0]       iss_sub,
   output logic [2:0]       iss_rm,
   output logic [31:0]      iss_a,
   output logic [31:0]      iss_b,
   output logic [31:0]      iss_c,
   input  logic             fu_done,
   input  logic [31:0]      fu_result,
   input  logic [4:0]       fu_exc,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic [4:0]       rsp_exc,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_illegal,
   input  logic             flush,
   output logic [4:0]       fflags,
   input  logic             fflags_clr,
   output logic             irq
);
   localparam int unsigned CAW = $clog2(CMD_DEPTH);
   localparam int unsigned RAW = $clog2(RSP_DEPTH);

   typedef enum logic {IDLE, EXEC} state_t;
   typedef logic [CAW:0] cptr_t;
   typedef logic [RAW:0] rptr_t;

   typedef struct packed {
      logic [3:0]       op;
      logic [1:0]       sub;
      logic [2:0]       rm;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [31:0]      c;
      logic [TAG_W-1:0] tag;
   } cmd_t;

   typedef struct packed {
      logic [31:0]      data;
      logic [4:0]       exc;
      logic [TAG_W-1:0] tag;
      logic             illegal;
   } rsp_t;

   state_t     state_q, state_d;
   cmd_t       cmd_mem_q [CMD_DEPTH];
   cmd_t       cmd_mem_d [CMD_DEPTH];
   rsp_t       rsp_mem_q [RSP_DEPTH];
   rsp_t       rsp_mem_d [RSP_DEPTH];
   cptr_t      cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
   rptr_t      rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d;
   logic [4:0] fflags_q, fflags_d;
   logic       irq_q, irq_d;

   cmd_t cmd_in, cmd_head;
   rsp_t rsp_head, rsp_wdata;
   logic cmd_full, cmd_empty, rsp_full, rsp_empty;
   logic cmd_push, cmd_pop, rsp_push, rsp_pop;
   logic head_illegal, timeout_hit;

   assign cmd_full  = (cmd_wp_q[CAW] != cmd_rp_q[CAW]) && (cmd_wp_q[CAW-1:0] == cmd_rp_q[CAW-1:0]);
   assign cmd_empty = (cmd_wp_q == cmd_rp_q);
   assign rsp_full  = (rsp_wp_q[RAW] != rsp_rp_q[RAW]) && (rsp_wp_q[RAW-1:0] == rsp_rp_q[RAW-1:0]);
   assign rsp_empty = (rsp_wp_q == rsp_rp_q);

   assign cmd_in   = '{op: cmd_op, sub: cmd_sub, rm: cmd_rm, a: cmd_a, b: cmd_b, c: cmd_c, tag: cmd_tag};
   assign cmd_head = cmd_mem_q[cmd_rp_q[CAW-1:0]];
   assign rsp_head = rsp_mem_q[rsp_rp_q[RAW-1:0]];

   assign cmd_push = cmd_valid && !cmd_full && !flush;
   assign rsp_pop  = !rsp_empty && rsp_ready;

   assign head_illegal = (32'(cmd_head.op) >= NUM_OPS) ||
                         (((cmd_head.op == 4'd1) || (cmd_head.op == 4'd2)) && (cmd_head.sub == 2'd3));

`ifdef FPQ_TIMEOUT_EN
   localparam int unsigned TOW = $clog2(TIMEOUT) + 1;
   logic [TOW-1:0] to_cnt_q, to_cnt_d;

   // Held at zero in IDLE, so every EXEC visit starts counting from 0.
   always_comb to_cnt_d = (state_q == EXEC && !flush) ? to_cnt_q + TOW'(1) : '0;
   assign timeout_hit = (state_q == EXEC) && !fu_done && (to_cnt_q == TOW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) to_cnt_q <= '0;
      else     to_cnt_q <= to_cnt_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!cmd_empty && !rsp_full && !head_illegal) state_d = EXEC;
         EXEC:    if (fu_done || timeout_hit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   // Response FIFO cannot be full in EXEC: entry required a free slot and only this FSM pushes.
   always_comb begin
      cmd_pop   = 1'b0;
      rsp_push  = 1'b0;
      rsp_wdata = '0;
      if (!flush) begin
         if (state_q == IDLE) begin
            if (!cmd_empty && !rsp_full && head_illegal) begin
               rsp_push          = 1'b1;
               cmd_pop           = 1'b1;
               rsp_wdata.tag     = cmd_head.tag;
               rsp_wdata.illegal = 1'b1;
            end
         end else if (fu_done) begin
            rsp_push       = 1'b1;
            cmd_pop        = 1'b1;
            rsp_wdata.data = fu_result;
            rsp_wdata.exc  = fu_exc;
            rsp_wdata.tag  = cmd_head.tag;
         end else if (timeout_hit) begin
            rsp_push          = 1'b1;
            cmd_pop           = 1'b1;
            rsp_wdata.exc     = 5'b10000;
            rsp_wdata.tag     = cmd_head.tag;
            rsp_wdata.illegal = 1'b1;
         end
      end
   end

   always_comb begin
      cmd_mem_d = cmd_mem_q;
      rsp_mem_d = rsp_mem_q;
      if (cmd_push) cmd_mem_d[cmd_wp_q[CAW-1:0]] = cmd_in;
      if (rsp_push) rsp_mem_d[rsp_wp_q[RAW-1:0]] = rsp_wdata;
      cmd_wp_d = cmd_wp_q + cptr_t'(cmd_push);
      cmd_rp_d = cmd_rp_q + cptr_t'(cmd_pop);
      rsp_wp_d = rsp_wp_q + rptr_t'(rsp_push);
      rsp_rp_d = rsp_rp_q + rptr_t'(rsp_pop && !flush);
      if (flush) begin
         cmd_wp_d = '0;
         cmd_rp_d = '0;
         rsp_wp_d = '0;
         rsp_rp_d = '0;
      end
   end

   always_comb begin
      fflags_d = fflags_q;
      if (!flush) begin
         if (fflags_clr)   fflags_d = '0;
         else if (rsp_pop) fflags_d = fflags_q | rsp_head.exc;
      end
      irq_d = !rsp_empty;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cmd_wp_q <= '0;
         cmd_rp_q <= '0;
         rsp_wp_q <= '0;
         rsp_rp_q <= '0;
         fflags_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cmd_wp_q <= cmd_wp_d;
         cmd_rp_q <= cmd_rp_d;
         rsp_wp_q <= rsp_wp_d;
         rsp_rp_q <= rsp_rp_d;
         fflags_q <= fflags_d;
         irq_q    <= irq_d;
      end
   end

   always_ff @(posedge clk) begin
      cmd_mem_q <= cmd_mem_d;
      rsp_mem_q <= rsp_mem_d;
   end

   always_comb begin
      cmd_ready   = !cmd_full;
      iss_valid   = 1'b0;
      iss_op      = '0;
      iss_sub     = '0;
      iss_rm      = '0;
      iss_a       = '0;
      iss_b       = '0;
      iss_c       = '0;
      if (state_q == EXEC) begin
         iss_valid = 1'b1;
         iss_op    = cmd_head.op;
         iss_sub   = cmd_head.sub;
         iss_rm    = cmd_head.rm;
         iss_a     = cmd_head.a;
         iss_b     = cmd_head.b;
         iss_c     = cmd_head.c;
      end
      rsp_valid   = !rsp_empty;
      rsp_data    = rsp_empty ? '0 : rsp_head.data;
      rsp_exc     = rsp_empty ? '0 : rsp_head.exc;
      rsp_tag     = rsp_empty ? '0 : rsp_head.tag;
      rsp_illegal = rsp_empty ? 1'b0 : rsp_head.illegal;
      fflags      = fflags_q;
      irq         = irq_q;
   end

endmodule

// File: tb/tb_fpu_op_queue.sv
// Bench for fpu_op_queue: directed scenarios plus random traffic against a queue-level reference model.
`timescale 1ns/1ps
module tb_fpu_op_queue;
   localparam int CMD_DEPTH = 4;
   localparam int RSP_DEPTH = 4;
   localparam int TAG_W     = 4;
   localparam int NUM_OPS   = 11;
   localparam int TIMEOUT   = 64;

   logic             clk, rst;
   logic             cmd_valid, cmd_ready;
   logic [3:0]       cmd_op;
   logic [1:0]       cmd_sub;
   logic [2:0]       cmd_rm;
   logic [31:0]      cmd_a, cmd_b, cmd_c;
   logic [TAG_W-1:0] cmd_tag;
   logic             iss_valid;
   logic [3:0]       iss_op;
   logic [1:0]       iss_sub;
   logic [2:0]       iss_rm;
   logic [31:0]      iss_a, iss_b, iss_c;
   logic             fu_done;
   logic [31:0]      fu_result;
   logic [4:0]       fu_exc;
   logic             rsp_valid, rsp_ready;
   logic [31:0]      rsp_data;
   logic [4:0]       rsp_exc;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_illegal;
   logic             flush;
   logic [4:0]       fflags;
   logic             fflags_clr;
   logic             irq;

   fpu_op_queue #(
      .CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH), .TAG_W(TAG_W),
      .NUM_OPS(NUM_OPS), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_sub(cmd_sub),
      .cmd_rm(cmd_rm), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_tag(cmd_tag),
      .iss_valid(iss_valid), .iss_op(iss_op), .iss_sub(iss_sub), .iss_rm(iss_rm),
      .iss_a(iss_a), .iss_b(iss_b), .iss_c(iss_c),
      .fu_done(fu_done), .fu_result(fu_result), .fu_exc(fu_exc),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_exc(rsp_exc),
      .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal),
      .flush(flush), .fflags(fflags), .fflags_clr(fflags_clr), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] op; logic [1:0] sub; logic [2:0] rm;
      logic [31:0] a; logic [31:0] b; logic [31:0] c; logic [TAG_W-1:0] tag;
   } mcmd_t;
   typedef struct {
      logic [31:0] data; logic [4:0] exc; logic [TAG_W-1:0] tag; logic ill;
   } mrsp_t;

   mcmd_t       cmdq[$];
   mrsp_t       rspq[$];
   bit          m_exec;
   int unsigned m_cnt;
   logic [4:0]  m_ff;
   logic        m_irq;

   int          checks, failures;
   int          unit_mode;     // 0 done at once, 1 fixed latency, 2 never, 3 random, 4 always high
   int unsigned unit_lat;
   logic [31:0] unit_res;
   logic [4:0]  unit_exc;
   bit          saw_iss;
   int          exec_seen;

   function automatic bit is_illegal(mcmd_t c);
      return (int'(c.op) >= NUM_OPS) || (((c.op == 4'd1) || (c.op == 4'd2)) && (c.sub == 2'd3));
   endfunction

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [104:0] exp_iss;
      chk("cmd_ready", cmd_ready, cmdq.size() < CMD_DEPTH);
      chk("rsp_valid", rsp_valid, rspq.size() > 0);
      if (rspq.size() > 0) begin
         chk("rsp_data", rsp_data, rspq[0].data);
         chk("rsp_exc", rsp_exc, rspq[0].exc);
         chk("rsp_tag", rsp_tag, rspq[0].tag);
         chk("rsp_illegal", rsp_illegal, rspq[0].ill);
      end
      exp_iss = '0;
      if (m_exec) exp_iss = {cmdq[0].op, cmdq[0].sub, cmdq[0].rm, cmdq[0].a, cmdq[0].b, cmdq[0].c};
      chk("iss_valid", iss_valid, m_exec);
      chk("iss_bus", {iss_op, iss_sub, iss_rm, iss_a, iss_b, iss_c}, exp_iss);
      chk("fflags", fflags, m_ff);
      chk("irq", irq, m_irq);
      if (iss_valid === 1'b1) begin
         saw_iss = 1'b1;
         exec_seen++;
      end
   endtask

   // Applies this cycle's inputs to the model, advances one clock, then compares.
   task automatic cycle();
      mrsp_t r;
      bit    have, done, pop, push, nirq;
      int    cs, rs;
      case (unit_mode)
         0: fu_done = m_exec;
         1: fu_done = m_exec && (m_cnt == unit_lat - 1);
         2: fu_done = 1'b0;
         3: begin
            fu_done  = ($urandom_range(0, 2) == 0);
            unit_res = $urandom;
            unit_exc = 5'($urandom);
         end
         default: fu_done = 1'b1;
      endcase
      fu_result = unit_res;
      fu_exc    = unit_exc;
      cs   = cmdq.size();
      rs   = rspq.size();
      pop  = (rs > 0) && rsp_ready;
      push = cmd_valid && (cs < CMD_DEPTH);
      nirq = (rs > 0);
      have = 1'b0;
      done = 1'b0;
      r    = '{32'h0, 5'h0, '0, 1'b0};
      if (flush) begin
         cmdq.delete();
         rspq.delete();
         m_exec = 1'b0;
      end else begin
         if (fflags_clr) m_ff = '0;
         else if (pop)   m_ff = m_ff | rspq[0].exc;
         if (!m_exec) begin
            if ((cs > 0) && (rs < RSP_DEPTH)) begin
               if (is_illegal(cmdq[0])) begin
                  r = '{32'h0, 5'h0, cmdq[0].tag, 1'b1};
                  have = 1'b1;
                  done = 1'b1;
               end else begin
                  m_exec = 1'b1;
                  m_cnt  = 0;
               end
            end
         end else if (fu_done) begin
            r = '{fu_result, fu_exc, cmdq[0].tag, 1'b0};
            have = 1'b1;
            done = 1'b1;
            m_exec = 1'b0;
         end
`ifdef FPQ_TIMEOUT_EN
         else if (m_cnt == TIMEOUT - 1) begin
            r = '{32'h0, 5'b10000, cmdq[0].tag, 1'b1};
            have = 1'b1;
            done = 1'b1;
            m_exec = 1'b0;
         end
`endif
         else m_cnt++;
         if (pop)  void'(rspq.pop_front());
         if (have) rspq.push_back(r);
         if (done) void'(cmdq.pop_front());
         if (push) cmdq.push_back('{cmd_op, cmd_sub, cmd_rm, cmd_a, cmd_b, cmd_c, cmd_tag});
      end
      m_irq = nirq;
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic push_cmd(logic [3:0] op, logic [1:0] sub, logic [31:0] a, logic [31:0] b,
                           logic [31:0] c, logic [TAG_W-1:0] tag);
      cmd_op = op; cmd_sub = sub; cmd_rm = 3'($urandom);
      cmd_a = a; cmd_b = b; cmd_c = c; cmd_tag = tag;
      cmd_valid = 1'b1;
      cycle();
      cmd_valid = 1'b0;
   endtask

   task automatic push_legal();
      push_cmd(4'($urandom_range(3, 10)), 2'($urandom), $urandom, $urandom, $urandom, TAG_W'($urandom));
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_sub = '0; cmd_rm = '0;
      cmd_a = '0; cmd_b = '0; cmd_c = '0; cmd_tag = '0;
      fu_done = 1'b0; fu_result = '0; fu_exc = '0;
      rsp_ready = 1'b0; flush = 1'b0; fflags_clr = 1'b0;
      m_exec = 1'b0; m_cnt = 0; m_ff = '0; m_irq = 1'b0;
      unit_mode = 0; unit_lat = 1; unit_res = '0; unit_exc = '0; saw_iss = 1'b0; exec_seen = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_all();
      chk("reset_cmd_ready", cmd_ready, 1'b1);

      // Single op, unit answers in the first EXEC cycle.
      unit_res = 32'h40C00000;
      push_cmd(4'd7, 2'd0, 32'h40000000, 32'h40400000, 32'h0, 4'd3);
      chk("lat_c1", rsp_valid, 1'b0);
      cycle();
      chk("lat_c2", rsp_valid, 1'b0);
      chk("lat_iss", iss_valid, 1'b1);
      cycle();
      chk("lat_c3", rsp_valid, 1'b1);
      chk("lat_data", rsp_data, 32'h40C00000);
      chk("lat_tag", rsp_tag, 4'd3);
      chk("lat_ill", rsp_illegal, 1'b0);
      chk("lat_irq_lag", irq, 1'b0);
      cycle();
      chk("lat_irq", irq, 1'b1);
      rsp_ready = 1'b1; cycle(); rsp_ready = 1'b0;

      // Fill the response FIFO, then the command FIFO behind it.
      unit_res = 32'h12345678;
      for (int i = 0; i < 4; i++) push_legal();
      idle(10);
      for (int i = 0; i < 4; i++) push_legal();
      chk("fill_cmd_ready", cmd_ready, 1'b0);
      idle(5);
      chk("fill_stall", iss_valid, 1'b0);
      rsp_ready = 1'b1; cycle(); rsp_ready = 1'b0;
      cycle();
      chk("drain_issue", iss_valid, 1'b1);
      rsp_ready = 1'b1; idle(30); rsp_ready = 1'b0;

      // Illegal heads are answered without issuing.
      saw_iss = 1'b0;
      push_cmd(4'd2, 2'd3, $urandom, $urandom, $urandom, 4'd5);
      push_cmd(4'd12, 2'd0, $urandom, $urandom, $urandom, 4'd6);
      idle(4);
      chk("illegal_no_issue", saw_iss, 1'b0);
      chk("illegal_1", {rsp_illegal, rsp_data, rsp_tag}, {1'b1, 32'h0, 4'd5});
      rsp_ready = 1'b1; cycle(); rsp_ready = 1'b0;
      chk("illegal_2", {rsp_illegal, rsp_data, rsp_tag}, {1'b1, 32'h0, 4'd6});
      rsp_ready = 1'b1; cycle(); rsp_ready = 1'b0;

      // Long divide: operands held for all 26 EXEC cycles, exception becomes sticky.
      fflags_clr = 1'b1; cycle(); fflags_clr = 1'b0;
      unit_mode = 1; unit_lat = 26; unit_exc = 5'b01000; unit_res = 32'h3F2AAAAB;
      exec_seen = 0;
      push_cmd(4'd9, 2'd0, 32'h40000000, 32'h40400000, 32'h0, 4'd9);
      for (int i = 0; i < 40 && rsp_valid !== 1'b1; i++) cycle();
      chk("div_done", rsp_valid, 1'b1);
      chk("div_exec_cycles", exec_seen, 26);
      rsp_ready = 1'b1; cycle(); rsp_ready = 1'b0;
      chk("div_fflags", fflags, 5'b01000);
      fflags_clr = 1'b1; cycle(); fflags_clr = 1'b0;
      chk("div_fflags_clr", fflags, 5'b00000);

      // Flush mid-EXEC with queued commands and pending responses.
      unit_mode = 0; unit_exc = 5'b00101;
      for (int i = 0; i < 3; i++) push_legal();
      idle(8);
      rsp_ready = 1'b1; cycle(); rsp_ready = 1'b0;
      unit_mode = 2;
      for (int i = 0; i < 3; i++) push_legal();
      chk("flush_pre_exec", iss_valid, 1'b1);
      chk("flush_pre_rsp", rsp_valid, 1'b1);
      flush = 1'b1; fflags_clr = 1'b1; rsp_ready = 1'b1; unit_mode = 4;
      cmd_valid = 1'b1; cmd_op = 4'd4;
      cycle();
      flush = 1'b0; fflags_clr = 1'b0; rsp_ready = 1'b0; cmd_valid = 1'b0; unit_mode = 0;
      chk("flush_iss", iss_valid, 1'b0);
      chk("flush_rsp", rsp_valid, 1'b0);
      chk("flush_cmd_ready", cmd_ready, 1'b1);
      chk("flush_fflags", fflags, 5'b00101);
      idle(3);
      chk("flush_cmd_empty", iss_valid, 1'b0);

`ifdef FPQ_TIMEOUT_EN
      // Unit never answers: timeout response, then the next command proceeds.
      unit_mode = 2; exec_seen = 0;
      push_cmd(4'd10, 2'd0, $urandom, 32'h0, 32'h0, 4'd10);
      push_cmd(4'd7, 2'd0, $urandom, $urandom, 32'h0, 4'd11);
      for (int i = 0; i < 90 && rsp_valid !== 1'b1; i++) cycle();
      chk("to_rsp", {rsp_valid, rsp_illegal, rsp_exc, rsp_tag}, {1'b1, 1'b1, 5'b10000, 4'd10});
      chk("to_cycles", exec_seen, 64);
      unit_mode = 0; rsp_ready = 1'b1; idle(8); rsp_ready = 1'b0;
      fflags_clr = 1'b1; cycle(); fflags_clr = 1'b0;
`endif

      // Random traffic.
      unit_mode = 3;
      for (int n = 0; n < 600; n++) begin
         cmd_valid  = 1'($urandom);
         cmd_op     = 4'($urandom_range(0, 15));
         cmd_sub    = 2'($urandom);
         cmd_rm     = 3'($urandom);
         cmd_a      = $urandom; cmd_b = $urandom; cmd_c = $urandom;
         cmd_tag    = TAG_W'($urandom);
         rsp_ready  = 1'($urandom);
         flush      = ($urandom_range(0, 49) == 0);
         fflags_clr = ($urandom_range(0, 19) == 0);
         cycle();
      end
      cmd_valid = 1'b0; flush = 1'b0; fflags_clr = 1'b0; unit_mode = 0; rsp_ready = 1'b1;
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
